// File: rtl/ip_stride_conf.sv
// ip_stride_conf
//   Confidence-based IP-stride prefetcher. Per-IP trackers learn a cache-line
//   stride from the demand access stream. Once a stride is confirmed, a short
//   burst of in-page line addresses is issued into a FWFT FIFO. When that FIFO
//   is full, new candidates are dropped and counted.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   acc_valid_i/acc_ready_o  demand access handshake
//   acc_addr_i, acc_ip_i     access byte address and instruction pointer
//   degree_i                 runtime prefetch degree, sampled at accept
//   pf_valid_o/pf_ready_i    prefetch FIFO head handshake
//   pf_addr_o                line-aligned prefetch address (0 when empty)
//   queue_count_o            FIFO occupancy
//   drop_count_o             saturating count of dropped candidates
module ip_stride_conf #(
  parameter int ADDR_W      = 64,
  parameter int IP_W        = 64,
  parameter int TRACKERS    = 64,
  parameter int DEGREE      = 4,
  parameter int LOG2_BLOCK  = 6,
  parameter int LOG2_PAGE   = 12,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             acc_valid_i,
  output logic                             acc_ready_o,
  input  logic [ADDR_W-1:0]                acc_addr_i,
  input  logic [IP_W-1:0]                  acc_ip_i,
  input  logic [$clog2(DEGREE+1)-1:0]      degree_i,
  output logic                             pf_valid_o,
  input  logic                             pf_ready_i,
  output logic [ADDR_W-1:0]                pf_addr_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o,
  output logic [15:0]                      drop_count_o
);

  localparam int CLA_W = ADDR_W - LOG2_BLOCK;
  localparam int PSH   = LOG2_PAGE - LOG2_BLOCK;
  localparam int PW    = ADDR_W - LOG2_PAGE;
  localparam int DW    = $clog2(DEGREE + 1);
  localparam int QCW   = $clog2(QUEUE_DEPTH + 1);
  localparam int QAW   = $clog2(QUEUE_DEPTH);
  localparam int RW    = $clog2(TRACKERS);

  typedef enum logic {IDLE, ISSUE} state_t;

  // tracker storage
  logic                 t_valid  [TRACKERS];
  logic [IP_W-1:0]      t_ip     [TRACKERS];
  logic [CLA_W-1:0]     t_cla    [TRACKERS];
  logic [CLA_W-1:0]     t_stride [TRACKERS];
  logic [CONF_BITS-1:0] t_conf   [TRACKERS];
  logic [RW-1:0]        t_rank   [TRACKERS];  // 0 = MRU, TRACKERS-1 = LRU

  // burst generator
  state_t           state;
  logic [CLA_W-1:0] cand_cla;
  logic [CLA_W-1:0] stride_r;
  logic [PW-1:0]    page_r;
  logic [DW-1:0]    deg_r;
  logic [DW-1:0]    k_r;

  // FIFO
  logic [ADDR_W-1:0] mem [QUEUE_DEPTH];
  logic [QAW-1:0]    wr_ptr, rd_ptr;
  logic [QCW-1:0]    count;
  logic [15:0]       drop_cnt;

  logic                 accept;
  logic                 hit, inv_found;
  logic [RW-1:0]        hit_idx, inv_idx, lru_idx, sel_idx, sel_rank;
  logic [CLA_W-1:0]     cla, stride;
  logic                 stride_nz, stride_eq;
  logic [CONF_BITS-1:0] conf_cur, conf_inc;
  logic [DW-1:0]        deg_eff;
  logic                 trigger;
  logic                 in_page, push, pop, full, empty, push_ok, drop;
  logic [ADDR_W-1:0]    push_addr;
  logic                 unused_low_bits;

  assign unused_low_bits = ^acc_addr_i[LOG2_BLOCK-1:0];

  assign acc_ready_o = (state == IDLE) & ~rst;
  assign accept      = acc_valid_i & acc_ready_o;
  assign cla         = acc_addr_i[ADDR_W-1:LOG2_BLOCK];

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_idx   = '0;
    for (int unsigned i = 0; i < TRACKERS; i++) begin
      if (!hit && t_valid[i] && (t_ip[i] == acc_ip_i)) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
      end
      if (!inv_found && !t_valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = RW'(i);
      end
      if (t_rank[i] == RW'(TRACKERS - 1))
        lru_idx = RW'(i);
    end
  end

  assign sel_idx   = hit ? hit_idx : (inv_found ? inv_idx : lru_idx);
  assign sel_rank  = t_rank[sel_idx];
  assign stride    = cla - t_cla[hit_idx];
  assign stride_nz = (stride != '0);
  assign stride_eq = (stride == t_stride[hit_idx]);
  assign conf_cur  = t_conf[hit_idx];
  assign conf_inc  = (conf_cur == '1) ? conf_cur : conf_cur + 1'b1;
  assign deg_eff   = (degree_i > DW'(DEGREE)) ? DW'(DEGREE) : degree_i;
  assign trigger   = accept & hit & stride_nz & stride_eq &
                     (int'(conf_inc) >= CONF_THRESH) & (deg_eff != '0);

  // Tracker training and true-LRU rank maintenance
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TRACKERS; i++) begin
        t_valid[i] <= 1'b0;
        t_conf[i]  <= '0;
        t_rank[i]  <= RW'(i);
      end
    end else if (accept) begin
      // every accept (miss, zero-stride hit, training hit) makes the entry MRU
      for (int unsigned i = 0; i < TRACKERS; i++) begin
        if (t_rank[i] < sel_rank)
          t_rank[i] <= t_rank[i] + 1'b1;
      end
      t_rank[sel_idx] <= '0;
      if (!hit) begin
        t_valid[sel_idx]  <= 1'b1;
        t_ip[sel_idx]     <= acc_ip_i;
        t_cla[sel_idx]    <= cla;
        t_stride[sel_idx] <= '0;
        t_conf[sel_idx]   <= '0;
      end else if (stride_nz) begin
        t_cla[hit_idx] <= cla;
        if (stride_eq)
          t_conf[hit_idx] <= conf_inc;
        else if (conf_cur == '0)
          t_stride[hit_idx] <= stride;
        else
          t_conf[hit_idx] <= conf_cur - 1'b1;
      end
    end
  end

  // cand_cla is the running base + k*stride, advanced by one stride per cycle
  assign in_page   = (cand_cla[CLA_W-1:PSH] == page_r);
  assign push      = (state == ISSUE) & in_page;
  assign push_addr = {cand_cla, {LOG2_BLOCK{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand_cla <= '0;
      stride_r <= '0;
      page_r   <= '0;
      deg_r    <= '0;
      k_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= ISSUE;
            cand_cla <= cla + stride;
            stride_r <= stride;
            page_r   <= acc_addr_i[ADDR_W-1:LOG2_PAGE];
            deg_r    <= deg_eff;
            k_r      <= DW'(1);
          end
        end
        ISSUE: begin
          if (!in_page || (k_r == deg_r)) begin
            state <= IDLE;
          end else begin
            k_r      <= k_r + 1'b1;
            cand_cla <= cand_cla + stride_r;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FWFT FIFO: a push into a full FIFO succeeds only alongside a pop
  assign full    = (count == QCW'(QUEUE_DEPTH));
  assign empty   = (count == '0);
  assign pop     = pf_ready_i & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (!push_ok && pop)
        count <= count - 1'b1;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign pf_valid_o    = ~empty;
  assign pf_addr_o     = empty ? '0 : mem[rd_ptr];
  assign queue_count_o = count;
  assign drop_count_o  = drop_cnt;

endmodule

// File: tb/tb_ip_stride_conf.sv
// tb_ip_stride_conf
//   Directed bench for ip_stride_conf (TRACKERS=4, other parameters default).
//   A table of single accesses, each followed by a fixed observation window,
//   covers training, page crossing, negative stride, degree clamping,
//   hysteresis and LRU eviction. Overflow and reset mid-burst are hand-written.
module tb_ip_stride_conf;

  logic        clk;
  logic        rst;
  logic        acc_valid_i;
  logic        acc_ready_o;
  logic [63:0] acc_addr_i;
  logic [63:0] acc_ip_i;
  logic [2:0]  degree_i;
  logic        pf_valid_o;
  logic        pf_ready_i;
  logic [63:0] pf_addr_o;
  logic [3:0]  queue_count_o;
  logic [15:0] drop_count_o;

  int errors = 0;
  int checks = 0;

  ip_stride_conf #(
    .TRACKERS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .acc_valid_i   (acc_valid_i),
    .acc_ready_o   (acc_ready_o),
    .acc_addr_i    (acc_addr_i),
    .acc_ip_i      (acc_ip_i),
    .degree_i      (degree_i),
    .pf_valid_o    (pf_valid_o),
    .pf_ready_i    (pf_ready_i),
    .pf_addr_o     (pf_addr_o),
    .queue_count_o (queue_count_o),
    .drop_count_o  (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              rst_first;
    logic [63:0]     ip;
    logic [63:0]     addr;
    logic [2:0]      deg;
    int              n_issue;  // cycles acc_ready_o stays low after accept
    int              npf;      // prefetches expected
    logic [3:0][63:0] pf;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [63:0] ip, input logic [63:0] addr,
                     input int d, input int ni, input int np,
                     input logic [63:0] a0 = 0, input logic [63:0] a1 = 0,
                     input logic [63:0] a2 = 0, input logic [63:0] a3 = 0);
    vec_t v;
    v.rst_first = r;
    v.ip        = ip;
    v.addr      = addr;
    v.deg       = 3'(d);
    v.n_issue   = ni;
    v.npf       = np;
    v.pf        = {a3, a2, a1, a0};
    vt.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // waits (bounded) for acc_ready_o, then presents one access for one cycle
  task automatic acc(input logic [63:0] ip, input logic [63:0] addr);
    int n;
    n = 0;
    @(negedge clk);
    while (!acc_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("acc_ready_timeout", 64'(acc_ready_o), 64'd1);
    acc_valid_i = 1'b1;
    acc_ip_i    = ip;
    acc_addr_i  = addr;
    @(negedge clk);
    acc_valid_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ovf_exp [8];
    rst         = 1'b1;
    acc_valid_i = 1'b0;
    acc_addr_i  = '0;
    acc_ip_i    = '0;
    degree_i    = 3'd3;
    pf_ready_i  = 1'b1;

    // ---------------- reset values ----------------
    @(negedge clk);
    @(negedge clk);
    chk("rst acc_ready", 64'(acc_ready_o), 64'd0);
    chk("rst pf_valid", 64'(pf_valid_o), 64'd0);
    chk("rst pf_addr", pf_addr_o, 64'd0);
    chk("rst queue_count", 64'(queue_count_o), 64'd0);
    chk("rst drop_count", 64'(drop_count_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst acc_ready", 64'(acc_ready_o), 64'd1);

    // ---------------- vector table ----------------
    // ascending stream
    add(1, 64'h400, 64'h1000, 3, 0, 0);
    add(0, 64'h400, 64'h1040, 3, 0, 0);
    add(0, 64'h400, 64'h1080, 3, 0, 0);
    add(0, 64'h400, 64'h10C0, 3, 3, 3, 64'h1100, 64'h1140, 64'h1180);
    // page cross: third candidate 0x2000 is out of page
    add(1, 64'h500, 64'h1D00, 3, 0, 0);
    add(0, 64'h500, 64'h1D80, 3, 0, 0);
    add(0, 64'h500, 64'h1E00, 3, 0, 0);
    add(0, 64'h500, 64'h1E80, 3, 3, 2, 64'h1F00, 64'h1F80);
    // negative stride, then degree 0, clamp 7->4, zero stride, degree 1
    add(1, 64'h600, 64'h3300, 3, 0, 0);
    add(0, 64'h600, 64'h32C0, 3, 0, 0);
    add(0, 64'h600, 64'h3280, 3, 0, 0);
    add(0, 64'h600, 64'h3240, 3, 3, 3, 64'h3200, 64'h31C0, 64'h3180);
    add(0, 64'h600, 64'h3200, 0, 0, 0);
    add(0, 64'h600, 64'h31C0, 7, 4, 4, 64'h3180, 64'h3140, 64'h3100, 64'h30C0);
    add(0, 64'h600, 64'h31C0, 3, 0, 0);
    add(0, 64'h600, 64'h3180, 1, 1, 1, 64'h3140);
    // hysteresis: two off-stride accesses drain conf 2->0, stride 1 kept
    add(1, 64'h400, 64'h1000, 3, 0, 0);
    add(0, 64'h400, 64'h1040, 3, 0, 0);
    add(0, 64'h400, 64'h1080, 3, 0, 0);
    add(0, 64'h400, 64'h10C0, 3, 3, 3, 64'h1100, 64'h1140, 64'h1180);
    add(0, 64'h400, 64'h1200, 3, 0, 0);
    add(0, 64'h400, 64'h1400, 3, 0, 0);
    add(0, 64'h400, 64'h1440, 3, 0, 0);
    add(0, 64'h400, 64'h1480, 3, 3, 3, 64'h14C0, 64'h1500, 64'h1540);
    // LRU: five new IPs evict IP 0x400, which then retrains from scratch
    for (int i = 0; i < 5; i++)
      add(0, 64'hA00 + 64'(i), 64'h9000 + 64'(i) * 64'h40, 3, 0, 0);
    add(0, 64'h400, 64'h14C0, 3, 0, 0);
    add(0, 64'h400, 64'h1500, 3, 0, 0);
    add(0, 64'h400, 64'h1540, 3, 0, 0);
    add(0, 64'h400, 64'h1580, 3, 3, 3, 64'h15C0, 64'h1600, 64'h1640);

    pf_ready_i = 1'b1;
    for (int r = 0; r < vt.size(); r++) begin
      if (vt[r].rst_first) do_reset();
      degree_i = vt[r].deg;
      chk($sformatf("row%0d ready_pre", r), 64'(acc_ready_o), 64'd1);
      acc_valid_i = 1'b1;
      acc_ip_i    = vt[r].ip;
      acc_addr_i  = vt[r].addr;
      @(negedge clk);
      acc_valid_i = 1'b0;
      for (int c = 1; c <= 7; c++) begin
        chk($sformatf("row%0d c%0d acc_ready", r, c), 64'(acc_ready_o),
            64'(c > vt[r].n_issue));
        if (c >= 2 && c - 2 < vt[r].npf) begin
          chk($sformatf("row%0d c%0d pf_valid", r, c), 64'(pf_valid_o), 64'd1);
          chk($sformatf("row%0d c%0d pf_addr", r, c), pf_addr_o, vt[r].pf[c-2]);
        end else begin
          chk($sformatf("row%0d c%0d pf_valid", r, c), 64'(pf_valid_o), 64'd0);
        end
        @(negedge clk);
      end
    end

    // ---------------- overflow ----------------
    do_reset();
    pf_ready_i = 1'b0;
    degree_i   = 3'd3;
    for (int i = 0; i < 4; i++) begin
      acc(64'h700, 64'h4000 + 64'(i) * 64'h40);
      acc(64'h800, 64'h6000 + 64'(i) * 64'h40);
      acc(64'h900, 64'h8000 + 64'(i) * 64'h40);
    end
    repeat (6) @(negedge clk);
    chk("ovf queue_count", 64'(queue_count_o), 64'd8);
    chk("ovf drop_count", 64'(drop_count_o), 64'd1);
    chk("ovf acc_ready", 64'(acc_ready_o), 64'd1);
    ovf_exp = '{64'h4100, 64'h4140, 64'h4180, 64'h6100, 64'h6140, 64'h6180,
                64'h8100, 64'h8140};
    pf_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d pf_valid", j), 64'(pf_valid_o), 64'd1);
      chk($sformatf("drain%0d pf_addr", j), pf_addr_o, ovf_exp[j]);
      @(negedge clk);
    end
    chk("drain empty pf_valid", 64'(pf_valid_o), 64'd0);
    chk("drain queue_count", 64'(queue_count_o), 64'd0);
    chk("drain drop_count", 64'(drop_count_o), 64'd1);

    // ---------------- reset mid-burst ----------------
    do_reset();
    pf_ready_i = 1'b0;
    degree_i   = 3'd4;
    acc(64'h400, 64'h1000);
    acc(64'h400, 64'h1040);
    acc(64'h400, 64'h1080);
    acc(64'h400, 64'h10C0);
    chk("mid T+1 acc_ready", 64'(acc_ready_o), 64'd0);
    @(negedge clk);
    chk("mid T+2 pf_valid", 64'(pf_valid_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid in-rst acc_ready", 64'(acc_ready_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid post pf_valid", 64'(pf_valid_o), 64'd0);
    chk("mid post queue_count", 64'(queue_count_o), 64'd0);
    chk("mid post acc_ready", 64'(acc_ready_o), 64'd1);
    chk("mid post drop_count", 64'(drop_count_o), 64'd0);
    acc(64'h400, 64'h1100);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("mid realloc c%0d acc_ready", c), 64'(acc_ready_o), 64'd1);
      chk($sformatf("mid realloc c%0d pf_valid", c), 64'(pf_valid_o), 64'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_stride_conf.md
# ip_stride_conf

Confidence-based, parametrised IP-stride prefetcher for the L1D prefetch path. It trains per-instruction-pointer stride trackers on a valid/ready access stream. Once a tracker's stride is confirmed, it emits a burst of up to DEGREE in-page prefetch line addresses, one per cycle, into an internal FIFO. The FIFO drains to the prefetch queue through a valid/ready port. Full-FIFO candidates are dropped and counted, so the block never back-pressures on the prefetch side.

## Interface
- ADDR_W, 64, access/prefetch address width
- IP_W, 64, instruction pointer width
- TRACKERS, 64, tracker entries (≥2)
- DEGREE, 4, maximum prefetch degree (≥1)
- LOG2_BLOCK, 6, log2 cache line bytes
- LOG2_PAGE, 12, log2 page bytes (> LOG2_BLOCK)
- CONF_BITS, 2, saturating confidence counter width
- CONF_THRESH, 2, minimum confidence to issue
- QUEUE_DEPTH, 8, output FIFO entries (power of 2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- acc_valid_i  in  1  demand access present
- acc_ready_o  out  1  block can accept access
- acc_addr_i  in  ADDR_W  demand byte address
- acc_ip_i  in  IP_W  IP of the access
- degree_i  in  $clog2(DEGREE+1)  runtime degree, sampled at accept
- pf_valid_o  out  1  FIFO head valid
- pf_ready_i  in  1  consumer takes head
- pf_addr_o  out  ADDR_W  line-aligned prefetch address (low LOG2_BLOCK bits 0)
- queue_count_o  out  $clog2(QUEUE_DEPTH+1)  FIFO occupancy
- drop_count_o  out  16  dropped candidates, saturating

## Operation
- CLA_W = ADDR_W−LOG2_BLOCK; cla = acc_addr_i>>LOG2_BLOCK. Stride = cla−last_cla, CLA_W-bit two's complement, signed.
- Tracker: valid, ip tag, last_cla, last_stride (signed CLA_W), conf (CONF_BITS), LRU rank. A match requires valid and tag equality.
- Accept occurs when acc_valid_i & acc_ready_o. Lookup is combinational in the accept cycle; the tracker update lands at the next edge.
- Miss: allocate the lowest-index invalid entry; if none is invalid, allocate the LRU entry. Set ip, last_cla=cla, last_stride=0, conf=0, and make it MRU. No prefetch.
- Hit, stride==0: set MRU only. No training, no prefetch.
- Hit, stride==last_stride: conf saturating-increments.
- Hit, stride≠last_stride: if conf==0, last_stride←stride; otherwise conf decrements.
- On any nonzero-stride hit, last_cla←cla and the entry becomes MRU. LRU is true-LRU rank: entries with rank below the hit's rank increment.
- Trigger: stride==last_stride and the post-update conf ≥ CONF_THRESH, with effective degree d≥1.
- Effective degree: d = min(degree_i, DEGREE). d=0 disables issue; training still occurs.
- FSM IDLE→ISSUE on trigger. Latch base cla, stride, page = acc_addr_i>>LOG2_PAGE, d, and set k=1.
- In each ISSUE cycle, form candidate (base+k·stride)<<LOG2_BLOCK.
  - If the candidate is in the base page, push it (drop and count if the FIFO is full without a simultaneous pop).
  - If it is out of page, push nothing.
- Return to IDLE when k==d or the candidate is out of page; otherwise k++. No later candidates are evaluated after a page cross.
- acc_ready_o = (state==IDLE) & ~rst.
- FIFO is first-word-fall-through. A push when full together with a pop succeeds (count unchanged). A pop when empty is ignored.
- rst, including mid-burst: all trackers invalid, conf/LRU ranks = index order, FSM IDLE, FIFO empty, drop count 0.

## Timing
- Reset values: acc_ready_o 0 during rst and 1 the cycle after; pf_valid_o 0; pf_addr_o 0; queue_count_o 0; drop_count_o 0.
- Accept at cycle T triggers: ISSUE occupies T+1..T+n, where n = min(d, index of the first out-of-page k).
- acc_ready_o is low over T+1..T+n and high at T+n+1.
- The k-th candidate pushed at the end of cycle T+k is visible on pf_valid_o/pf_addr_o from T+k+1 if the FIFO was empty.
- Non-trigger accepts leave acc_ready_o high; back-to-back accepts are supported.
- Tracker state written at T is visible to a same-IP access at T+1.
- Drop count updates at the edge of the dropped push.

## Test plan
- Ascending stream: IP 0x400, addresses 0x1000, 0x1040, 0x1080, 0x10C0, degree_i=3, pf_ready_i=1 → 4th access triggers; outputs 0x1100, 0x1140, 0x1180 on consecutive cycles; acc_ready_o low for 3 cycles.
- Page cross: IP 0x500, addresses 0x1D00, 0x1D80, 0x1E00, 0x1E80, degree 3 → only 0x1F00 and 0x1F80 are emitted; ISSUE ends after 3 cycles; 0x2000 is never emitted.
- Negative stride: IP 0x600, addresses 0x3300, 0x32C0, 0x3280, 0x3240, degree 3 → outputs 0x3200, 0x31C0, 0x3180.
- Overflow: pf_ready_i=0, three interleaved trained IPs each triggering degree 3 → queue_count_o=8, drop_count_o=1. Then assert pf_ready_i → 8 addresses drain in push order.
- Hysteresis and LRU: TRACKERS=4. Train IP 0x400, inject one off-stride access → conf decrements, no issue, last_stride kept. Then access 5 new IPs → IP 0x400 is evicted, and its next access misses and allocates with conf=0.
- Reset mid-burst: assert rst at T+2 of a degree-4 burst → the cycle after rst, pf_valid_o=0, queue_count_o=0, acc_ready_o=1, and the next access to the previously trained IP allocates (no prefetch).
